trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
//
// Purpose:
//   Machine-mode trap sequencer. Watches the instruction in EX for a
//   synchronous exception, an enabled pending interrupt (external, software,
//   timer) or an MRET, and turns the winning event into a short, fixed
//   sequence of strobes towards the CSR file and the fetch unit:
//     trap:  IDLE -> SAVE (CSR write of mepc/mcause/mtval) -> JUMP (redirect)
//     mret:  IDLE -> MRET (CSR restore strobe + redirect to mepc)
//   The pipeline front end is flushed in every non-IDLE state.
//
// Parameters:
//   DW            datapath width of PC, cause and tval buses (default 64)
//
// Configuration macro:
//   TRAP_IRQ_SYNC_EN  when defined, ext_irq_i passes through a 2-flop
//                     synchronizer (reset to 0) before use, adding two
//                     cycles of detection latency. Undefined: used directly.
//
// Ports:
//   clk, rst                         clock (rising edge), async active-high reset
//   ex_valid_i, ex_pc_i              valid instruction in EX and its PC
//   exp_i, exp_cause_i, exp_tval_i   synchronous exception, code, fault value
//   mret_i                           MRET in EX
//   ext_irq_i, sft_irq_i, tmr_irq_i  level interrupt sources
//   glb_irq_i, meie_i, msie_i, mtie_i  interrupt enables from the CSR file
//   irq_pc_i, mepc_i                 trap entry PC and return PC from the CSRs
//   trap_o, irq_src_o, exp_src_o     CSR trap-write strobe and trap kind
//   trap_pc_o, mcause_o, mtval_o     values to write into mepc/mcause/mtval
//   mret_ena_o                       MRET strobe to the CSR file
//   flush_o, jump_o, jump_pc_o       pipeline kill, PC redirect and target
//   busy_o                           sequencer not idle
// ---------------------------------------------------------------------------
module trap_ctrl #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          ex_valid_i,
    input  logic [DW-1:0] ex_pc_i,

    input  logic          exp_i,
    input  logic [3:0]    exp_cause_i,
    input  logic [DW-1:0] exp_tval_i,

    input  logic          mret_i,

    input  logic          ext_irq_i,
    input  logic          sft_irq_i,
    input  logic          tmr_irq_i,

    input  logic          glb_irq_i,
    input  logic          meie_i,
    input  logic          msie_i,
    input  logic          mtie_i,

    input  logic [DW-1:0] irq_pc_i,
    input  logic [DW-1:0] mepc_i,

    output logic          trap_o,
    output logic          irq_src_o,
    output logic          exp_src_o,
    output logic [DW-1:0] trap_pc_o,
    output logic [DW-1:0] mcause_o,
    output logic [DW-1:0] mtval_o,

    output logic          mret_ena_o,

    output logic          flush_o,
    output logic          jump_o,
    output logic [DW-1:0] jump_pc_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAVE = 2'd1,
        JUMP = 2'd2,
        MRET = 2'd3
    } state_t;

    // Interrupt causes carry the interrupt flag in the MSB.
    localparam logic [DW-1:0] CAUSE_EXT = {1'b1, (DW-1)'(11)};
    localparam logic [DW-1:0] CAUSE_SFT = {1'b1, (DW-1)'(3)};
    localparam logic [DW-1:0] CAUSE_TMR = {1'b1, (DW-1)'(7)};

    state_t        state_q, state_d;
    logic [DW-1:0] pc_q,    pc_d;
    logic [DW-1:0] cause_q, cause_d;
    logic [DW-1:0] tval_q,  tval_d;
    logic          irq_q,   irq_d;

    logic          ext_irq;
    logic          ext_pend;
    logic          sft_pend;
    logic          tmr_pend;

`ifdef TRAP_IRQ_SYNC_EN
    // The external line may come from another clock domain; two flops give
    // metastability settling time before it reaches the priority logic.
    logic [1:0] ext_sync_q, ext_sync_d;

    assign ext_sync_d = {ext_sync_q[0], ext_irq_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_sync_q <= 2'b00;
        end else begin
            ext_sync_q <= ext_sync_d;
        end
    end

    assign ext_irq = ext_sync_q[1];
`else
    assign ext_irq = ext_irq_i;
`endif

    assign ext_pend = glb_irq_i & meie_i & ext_irq;
    assign sft_pend = glb_irq_i & msie_i & sft_irq_i;
    assign tmr_pend = glb_irq_i & mtie_i & tmr_irq_i;

    // State and capture registers. Reset clears everything so that a trap
    // cut short by reset leaves no stale mepc/mcause/mtval on the buses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            tval_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
            irq_q   <= irq_d;
        end
    end

    // Next-state, capture and strobe logic. Events are only looked at in
    // IDLE; level interrupts simply stay asserted and are picked up again
    // once the sequence has returned to IDLE.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cause_d    = cause_q;
        tval_d     = tval_q;
        irq_d      = irq_q;

        trap_o     = 1'b0;
        irq_src_o  = 1'b0;
        exp_src_o  = 1'b0;
        mret_ena_o = 1'b0;
        flush_o    = 1'b0;
        jump_o     = 1'b0;
        jump_pc_o  = '0;

        case (state_q)
            IDLE: begin
                if (ex_valid_i) begin
                    if (exp_i) begin
                        pc_d    = ex_pc_i;
                        cause_d = {{(DW-4){1'b0}}, exp_cause_i};
                        tval_d  = exp_tval_i;
                        irq_d   = 1'b0;
                        state_d = SAVE;
                    end else if (ext_pend) begin
                        pc_d    = ex_pc_i;
                        cause_d = CAUSE_EXT;
                        tval_d  = '0;
                        irq_d   = 1'b1;
                        state_d = SAVE;
                    end else if (sft_pend) begin
                        pc_d    = ex_pc_i;
                        cause_d = CAUSE_SFT;
                        tval_d  = '0;
                        irq_d   = 1'b1;
                        state_d = SAVE;
                    end else if (tmr_pend) begin
                        pc_d    = ex_pc_i;
                        cause_d = CAUSE_TMR;
                        tval_d  = '0;
                        irq_d   = 1'b1;
                        state_d = SAVE;
                    end else if (mret_i) begin
                        state_d = MRET;
                    end
                end
            end

            SAVE: begin
                trap_o    = 1'b1;
                irq_src_o = irq_q;
                exp_src_o = ~irq_q;
                flush_o   = 1'b1;
                state_d   = JUMP;
            end

            // The CSR file has absorbed the trap write by now, so irq_pc_i
            // already reflects the post-trap vector.
            JUMP: begin
                jump_o    = 1'b1;
                jump_pc_o = irq_pc_i;
                flush_o   = 1'b1;
                state_d   = IDLE;
            end

            MRET: begin
                mret_ena_o = 1'b1;
                jump_o     = 1'b1;
                jump_pc_o  = mepc_i;
                flush_o    = 1'b1;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // mepc must be instruction aligned, so bit 0 is never written.
    assign trap_pc_o = pc_q & ~DW'(1);
    assign mcause_o  = cause_q;
    assign mtval_o   = tval_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl
//
// Testbench for trap_ctrl. A reference model keeps a queue of the output
// cycles each accepted event is going to produce; while the queue holds
// entries the controller is considered busy and ignores new events. Directed
// scenarios cover the documented examples, followed by randomized traffic
// with occasional asynchronous resets.
// ---------------------------------------------------------------------------
module tb_trap_ctrl;

   localparam int DW = 64;
   localparam logic [DW-1:0] INT_EXT = 64'h8000_0000_0000_000B;
   localparam logic [DW-1:0] INT_SFT = 64'h8000_0000_0000_0003;
   localparam logic [DW-1:0] INT_TMR = 64'h8000_0000_0000_0007;

   logic          clk = 1'b0;
   logic          rst;
   logic          exValid;
   logic [DW-1:0] exPc;
   logic          expI;
   logic [3:0]    expCause;
   logic [DW-1:0] expTval;
   logic          mretI;
   logic          extIrq, sftIrq, tmrIrq;
   logic          glbIrq, meie, msie, mtie;
   logic [DW-1:0] irqPc, mepc;

   logic          trapO, irqSrcO, expSrcO, mretEnaO, flushO, jumpO, busyO;
   logic [DW-1:0] trapPcO, mcauseO, mtvalO, jumpPcO;

   typedef struct {
      logic          exValid;
      logic [DW-1:0] exPc;
      logic          expI;
      logic [3:0]    expCause;
      logic [DW-1:0] expTval;
      logic          mretI;
      logic          extIrq, sftIrq, tmrIrq;
      logic          glbIrq, meie, msie, mtie;
      logic [DW-1:0] irqPc, mepc;
   } stim_t;

   // One expected output cycle. sel: 0 no redirect, 1 irq_pc, 2 mepc.
   typedef struct {
      bit            trap;
      bit            irq;
      bit            exc;
      bit            mret;
      bit            jump;
      int            sel;
      logic [DW-1:0] pc;
      logic [DW-1:0] cause;
      logic [DW-1:0] tval;
   } rec_t;

   rec_t       sched[$];
   logic [1:0] extHist;
   int         checks   = 0;
   int         failures = 0;

   trap_ctrl #(.DW(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .ex_valid_i  (exValid),
      .ex_pc_i     (exPc),
      .exp_i       (expI),
      .exp_cause_i (expCause),
      .exp_tval_i  (expTval),
      .mret_i      (mretI),
      .ext_irq_i   (extIrq),
      .sft_irq_i   (sftIrq),
      .tmr_irq_i   (tmrIrq),
      .glb_irq_i   (glbIrq),
      .meie_i      (meie),
      .msie_i      (msie),
      .mtie_i      (mtie),
      .irq_pc_i    (irqPc),
      .mepc_i      (mepc),
      .trap_o      (trapO),
      .irq_src_o   (irqSrcO),
      .exp_src_o   (expSrcO),
      .trap_pc_o   (trapPcO),
      .mcause_o    (mcauseO),
      .mtval_o     (mtvalO),
      .mret_ena_o  (mretEnaO),
      .flush_o     (flushO),
      .jump_o      (jumpO),
      .jump_pc_o   (jumpPcO),
      .busy_o      (busyO)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic stim_t quietStim();
      stim_t s;
      s = '{default: '0};
      s.irqPc = 64'h0000_0000_8000_0000;
      s.mepc  = 64'h0000_0000_8000_0104;
      return s;
   endfunction

   task automatic driveInputs(input stim_t s);
      exValid  = s.exValid;
      exPc     = s.exPc;
      expI     = s.expI;
      expCause = s.expCause;
      expTval  = s.expTval;
      mretI    = s.mretI;
      extIrq   = s.extIrq;
      sftIrq   = s.sftIrq;
      tmrIrq   = s.tmrIrq;
      glbIrq   = s.glbIrq;
      meie     = s.meie;
      msie     = s.msie;
      mtie     = s.mtie;
      irqPc    = s.irqPc;
      mepc     = s.mepc;
   endtask

   task automatic pushTrap(input bit isIrq, input logic [DW-1:0] cause,
                           input logic [DW-1:0] tval);
      rec_t r;
      r       = '{default: '0};
      r.trap  = 1'b1;
      r.irq   = isIrq;
      r.exc   = !isIrq;
      r.pc    = {exPc[DW-1:1], 1'b0};
      r.cause = cause;
      r.tval  = tval;
      sched.push_back(r);
      r       = '{default: '0};
      r.jump  = 1'b1;
      r.sel   = 1;
      sched.push_back(r);
   endtask

   // Compares this cycle's outputs against the model, then lets the model
   // react to the inputs currently applied (only when it has nothing queued).
   task automatic evaluateModel();
      rec_t          r;
      rec_t          m;
      bit            idle;
      logic          extSeen;
      logic [DW-1:0] expJpc;

      r    = '{default: '0};
      idle = (sched.size() == 0);
      if (!idle) r = sched.pop_front();

      expJpc = (r.sel == 1) ? irqPc : ((r.sel == 2) ? mepc : '0);
      checkOutput("trap_o",     trapO,    r.trap);
      checkOutput("irq_src_o",  irqSrcO,  r.irq);
      checkOutput("exp_src_o",  expSrcO,  r.exc);
      checkOutput("mret_ena_o", mretEnaO, r.mret);
      checkOutput("jump_o",     jumpO,    r.jump);
      checkOutput("flush_o",    flushO,   r.trap | r.jump);
      checkOutput("busy_o",     busyO,    !idle);
      checkOutput("jump_pc_o",  jumpPcO,  expJpc);
      if (r.trap) begin
         checkOutput("trap_pc_o", trapPcO, r.pc);
         checkOutput("mcause_o",  mcauseO, r.cause);
         checkOutput("mtval_o",   mtvalO,  r.tval);
      end

`ifdef TRAP_IRQ_SYNC_EN
      extSeen = extHist[1];
`else
      extSeen = extIrq;
`endif

      if (idle && exValid) begin
         if (expI)
            pushTrap(1'b0, {60'b0, expCause}, expTval);
         else if (glbIrq && meie && extSeen)
            pushTrap(1'b1, INT_EXT, '0);
         else if (glbIrq && msie && sftIrq)
            pushTrap(1'b1, INT_SFT, '0);
         else if (glbIrq && mtie && tmrIrq)
            pushTrap(1'b1, INT_TMR, '0);
         else if (mretI) begin
            m      = '{default: '0};
            m.mret = 1'b1;
            m.jump = 1'b1;
            m.sel  = 2;
            sched.push_back(m);
         end
      end

      extHist = {extHist[0], extIrq};
   endtask

   // One clock cycle: inputs change just after the rising edge, outputs are
   // compared a step later, well before the next edge.
   task automatic applyStimulus(input stim_t s);
      @(posedge clk);
      #1;
      driveInputs(s);
      #1;
      evaluateModel();
   endtask

   // Asserts reset away from the clock edge, checks that everything dropped
   // immediately, and releases on a falling edge.
   task automatic applyReset();
      driveInputs(quietStim());
      rst = 1'b1;
      #1;
      checkOutput("rst_trap_o",     trapO,    '0);
      checkOutput("rst_irq_src_o",  irqSrcO,  '0);
      checkOutput("rst_exp_src_o",  expSrcO,  '0);
      checkOutput("rst_mret_ena_o", mretEnaO, '0);
      checkOutput("rst_flush_o",    flushO,   '0);
      checkOutput("rst_jump_o",     jumpO,    '0);
      checkOutput("rst_busy_o",     busyO,    '0);
      checkOutput("rst_jump_pc_o",  jumpPcO,  '0);
      checkOutput("rst_trap_pc_o",  trapPcO,  '0);
      checkOutput("rst_mcause_o",   mcauseO,  '0);
      checkOutput("rst_mtval_o",    mtvalO,   '0);
      sched.delete();
      extHist = 2'b00;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      stim_t s;
      int    latency;

      extHist = 2'b00;
      applyReset();
      applyStimulus(quietStim());
      applyStimulus(quietStim());

      // Synchronous exception with cause 2.
      s = quietStim();
      s.exValid = 1'b1; s.expI = 1'b1; s.expCause = 4'd2;
      s.expTval = 64'h13; s.exPc = 64'h8000_0100;
      applyStimulus(s);
      s = quietStim();
      applyStimulus(s);
      checkOutput("exc_trap_o",   trapO,   1'b1);
      checkOutput("exc_exp_src",  expSrcO, 1'b1);
      checkOutput("exc_mcause",   mcauseO, 64'd2);
      checkOutput("exc_mtval",    mtvalO,  64'h13);
      checkOutput("exc_trap_pc",  trapPcO, 64'h8000_0100);
      applyStimulus(s);
      checkOutput("exc_jump_o",   jumpO,   1'b1);
      checkOutput("exc_jump_pc",  jumpPcO, 64'h8000_0000);

      // Timer interrupt, then the same with the global enable off.
      s = quietStim();
      s.exValid = 1'b1; s.glbIrq = 1'b1; s.mtie = 1'b1; s.tmrIrq = 1'b1;
      s.exPc = 64'h200;
      applyStimulus(s);
      applyStimulus(quietStim());
      checkOutput("tmr_mcause",  mcauseO, INT_TMR);
      checkOutput("tmr_mtval",   mtvalO,  '0);
      checkOutput("tmr_irq_src", irqSrcO, 1'b1);
      checkOutput("tmr_trap_pc", trapPcO, 64'h200);
      applyStimulus(quietStim());
      s.glbIrq = 1'b0;
      applyStimulus(s);
      applyStimulus(quietStim());
      checkOutput("glb_off_trap_o", trapO, 1'b0);

      // All three interrupts pending: external first, then software.
      s = quietStim();
      s.glbIrq = 1'b1; s.meie = 1'b1; s.msie = 1'b1; s.mtie = 1'b1;
      s.extIrq = 1'b1; s.sftIrq = 1'b1; s.tmrIrq = 1'b1; s.exPc = 64'h400;
      for (int i = 0; i < 3; i++) applyStimulus(s);
      s.exValid = 1'b1;
      applyStimulus(s);
      s.extIrq = 1'b0;
      applyStimulus(s);
      checkOutput("prio_first_cause", mcauseO, INT_EXT);
      applyStimulus(s);
      applyStimulus(s);
      applyStimulus(s);
      checkOutput("prio_second_cause", mcauseO, INT_SFT);
      applyStimulus(quietStim());

      // Exception and external interrupt in the same cycle.
      s = quietStim();
      s.glbIrq = 1'b1; s.meie = 1'b1; s.extIrq = 1'b1; s.exPc = 64'h600;
      for (int i = 0; i < 3; i++) applyStimulus(s);
      s.exValid = 1'b1; s.expI = 1'b1; s.expCause = 4'd5; s.expTval = 64'hBAD;
      applyStimulus(s);
      s.expI = 1'b0;
      applyStimulus(s);
      checkOutput("exc_vs_irq_exp_src", expSrcO, 1'b1);
      checkOutput("exc_vs_irq_cause",   mcauseO, 64'd5);
      applyStimulus(s);
      applyStimulus(s);
      applyStimulus(s);
      checkOutput("exc_vs_irq_followup", trapO,   1'b1);
      checkOutput("exc_vs_irq_cause2",   mcauseO, INT_EXT);
      applyStimulus(quietStim());
      applyStimulus(quietStim());

      // MRET redirect.
      s = quietStim();
      s.exValid = 1'b1; s.mretI = 1'b1; s.mepc = 64'h8000_0104;
      applyStimulus(s);
      applyStimulus(quietStim());
      checkOutput("mret_ena",     mretEnaO, 1'b1);
      checkOutput("mret_jump_pc", jumpPcO,  64'h8000_0104);
      checkOutput("mret_flush",   flushO,   1'b1);
      applyStimulus(quietStim());
      checkOutput("mret_back_idle", busyO, 1'b0);

      // Reset in the middle of SAVE: no jump may follow.
      s = quietStim();
      s.exValid = 1'b1; s.expI = 1'b1; s.expCause = 4'd7; s.exPc = 64'h700;
      applyStimulus(s);
      applyStimulus(quietStim());
      checkOutput("pre_rst_trap_o", trapO, 1'b1);
      #1;
      applyReset();
      applyStimulus(quietStim());
      checkOutput("post_rst_no_jump", jumpO, 1'b0);
      applyStimulus(quietStim());

      // External interrupt latency from request to trap strobe.
      s = quietStim();
      s.exValid = 1'b1; s.glbIrq = 1'b1; s.meie = 1'b1; s.extIrq = 1'b1;
      latency = -1;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(s);
         if (trapO === 1'b1 && latency < 0) latency = i;
      end
`ifdef TRAP_IRQ_SYNC_EN
      checkOutput("ext_latency", latency, 3);
`else
      checkOutput("ext_latency", latency, 1);
`endif
      applyStimulus(quietStim());
      applyStimulus(quietStim());
      applyStimulus(quietStim());

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         s = quietStim();
         s.exValid  = ($urandom_range(0, 9) < 8);
         s.exPc     = {$urandom(), $urandom()};
         s.expI     = ($urandom_range(0, 9) < 2);
         s.expCause = 4'($urandom_range(0, 15));
         s.expTval  = {$urandom(), $urandom()};
         s.mretI    = ($urandom_range(0, 9) < 2);
         s.extIrq   = ($urandom_range(0, 9) < 3);
         s.sftIrq   = ($urandom_range(0, 9) < 3);
         s.tmrIrq   = ($urandom_range(0, 9) < 3);
         s.glbIrq   = ($urandom_range(0, 9) < 7);
         s.meie     = ($urandom_range(0, 9) < 7);
         s.msie     = ($urandom_range(0, 9) < 7);
         s.mtie     = ($urandom_range(0, 9) < 7);
         s.irqPc    = {$urandom(), $urandom()};
         s.mepc     = {$urandom(), $urandom()};
         applyStimulus(s);
         if ($urandom_range(0, 199) == 0) begin
            #1;
            applyReset();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time limit in case anything stalls the stimulus thread.
   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] timeout");
   end

endmodule
